// File: rtl/fetch_pkg.sv
// Shared types and opcode constants for the instruction-fetch front end.
// Latency: n/a (definitions only). Backpressure: n/a.
// Opcode field bounds follow the instruction layout {opcode, operand A, operand B}.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] OPC_HALT = 4'hF;
    localparam int         OPC_MSB  = 19;
    localparam int         OPC_LSB  = 16;

    function automatic logic is_halt_opc(input logic [OPC_MSB-OPC_LSB:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Purpose: 2-entry FIFO holding {pc, instr} pairs between fetch and decode.
// Latency: push visible at head one cycle later; head data is registered state.
// Backpressure: full when 2 entries; push on full is accepted only with a same-cycle pop.
module fetch_buf #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               clear,
    output logic               full,
    output logic               empty,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [ADDR_W-1:0]  pc_q    [2];
    logic [INSTR_W-1:0] instr_q [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               do_pop;
    logic               do_push;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]    <= push_pc;
                instr_q[wr_ptr] <= push_instr;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head reads as zero when empty so decode never sees stale entries.
    assign head_pc    = empty ? '0 : pc_q[rd_ptr];
    assign head_instr = empty ? '0 : instr_q[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Purpose: PC sequencer feeding decode through a 2-entry buffer; optional halt opcode via FETCH_HALT_EN.
// Latency: start at edge k -> first instruction valid after edge k+1; one instruction per cycle sustained.
// Backpressure: dec_ready low fills the buffer, then PC and imem_addr hold until decode pops.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 20,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               busy,
    output logic               halted
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              busy_q;
    logic              buf_full;
    logic              buf_empty;
    logic              pop;
    logic              fetch;
    logic              halt_hit;

    assign dec_valid = !buf_empty;
    assign pop       = dec_valid && dec_ready;
    // A pop frees a slot this cycle, so a full buffer can still take a fetch.
    assign fetch     = (state == ST_RUN) && !redirect_valid && (!buf_full || pop);
    assign imem_addr = pc;
    assign busy      = busy_q;

`ifdef FETCH_HALT_EN
    logic halted_q;
    assign halt_hit = fetch && is_halt_opc(imem_instr[OPC_MSB:OPC_LSB]);
    assign halted   = halted_q;
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            busy_q <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            if (state != ST_IDLE) begin
                state  <= ST_RUN;
                busy_q <= 1'b1;
`ifdef FETCH_HALT_EN
                halted_q <= 1'b0;
`endif
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fetch) begin
                        // The halt instruction itself is delivered; PC parks on it.
                        if (halt_hit) begin
                            state  <= ST_HALT;
                            busy_q <= 1'b0;
`ifdef FETCH_HALT_EN
                            halted_q <= 1'b1;
`endif
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch),
        .push_pc    (pc),
        .push_instr (imem_instr),
        .pop        (pop),
        .clear      (redirect_valid),
        .full       (buf_full),
        .empty      (buf_empty),
        .head_pc    (dec_pc),
        .head_instr (dec_instr)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: behavioural instruction memory and hand-computed expectations.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dec_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [7:0]  imem_addr;
    logic [19:0] imem_instr;
    logic        dec_valid;
    logic [19:0] dec_instr;
    logic [7:0]  dec_pc;
    logic        busy;
    logic        halted;

    logic [19:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    assign imem_instr = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_ctrl #(
        .ADDR_W   (8),
        .INSTR_W  (20),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .halted         (halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        dec_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
        n_checks++; if (dec_instr !== 20'h0 || dec_pc !== 8'h00) begin n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", dec_pc, dec_instr); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [19:0] exp_i [3];
        exp_i = '{20'h00503, 20'h00801, 20'h10802};
        do_reset();
        dec_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stream_busy: got %b want 1", busy); end
        n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b want 0", dec_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'(i) || dec_instr !== exp_i[i]) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, dec_valid, dec_pc, dec_instr, 8'(i), exp_i[i]);
            end
        end
    endtask

    task automatic test_raw_stall();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'h00 || dec_instr !== 20'h00503 || imem_addr !== 8'h02) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got pc=%h instr=%h addr=%h want pc=00 instr=00503 addr=02", i, dec_pc, dec_instr, imem_addr);
            end
        end
        dec_ready = 1'b1;
        step();
        n_checks++; if (dec_pc !== 8'h01 || dec_instr !== 20'h00801) begin n_fail++; $display("FAIL stall_rel1: got %h/%h want 01/00801", dec_pc, dec_instr); end
        step();
        n_checks++; if (dec_pc !== 8'h02 || dec_instr !== 20'h10802) begin n_fail++; $display("FAIL stall_rel2: got %h/%h want 02/10802", dec_pc, dec_instr); end
    endtask

    task automatic test_redirect();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        dec_ready = 1'b1;
        step();
        n_checks++; if (dec_pc !== 8'h01 || dec_valid !== 1'b1) begin n_fail++; $display("FAIL redir_pre: got pc=%h v=%b want 01/1", dec_pc, dec_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (dec_valid !== 1'b0 || imem_addr !== 8'h00 || busy !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got v=%b addr=%h busy=%b want 0/00/1", dec_valid, imem_addr, busy); end
        step();
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h00 || dec_instr !== 20'h00503) begin n_fail++; $display("FAIL redir_first: got v=%b %h/%h want 1 00/00503", dec_valid, dec_pc, dec_instr); end
        step();
        n_checks++; if (dec_pc !== 8'h01 || dec_instr !== 20'h00801) begin n_fail++; $display("FAIL redir_second: got %h/%h want 01/00801", dec_pc, dec_instr); end
    endtask

    task automatic test_pc_wrap();
        logic [7:0]  exp_pc [4];
        logic [19:0] exp_i  [4];
        exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_i  = '{20'h1FE01, 20'h1FF00, 20'h00503, 20'h00801};
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (imem_addr !== 8'hFE || busy !== 1'b0) begin n_fail++; $display("FAIL idle_redir: got addr=%h busy=%b want FE/0", imem_addr, busy); end
        step();
        n_checks++; if (dec_valid !== 1'b0 || imem_addr !== 8'hFE) begin n_fail++; $display("FAIL idle_nofetch: got v=%b addr=%h want 0/FE", dec_valid, imem_addr); end
        dec_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc[i] || dec_instr !== exp_i[i]) begin
                n_fail++;
                $display("FAIL wrap_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, dec_valid, dec_pc, dec_instr, exp_pc[i], exp_i[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_checks++; if (dec_valid !== 1'b1 || imem_addr !== 8'h02) begin n_fail++; $display("FAIL arst_pre: got v=%b addr=%h want 1/02", dec_valid, imem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (dec_valid !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL arst_now: got v=%b busy=%b addr=%h want 0/0/00", dec_valid, busy, imem_addr); end
        step();
        rst_n = 1'b1;
        dec_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h00 || dec_instr !== 20'h00503) begin n_fail++; $display("FAIL arst_refetch: got v=%b %h/%h want 1 00/00503", dec_valid, dec_pc, dec_instr); end
    endtask

    task automatic test_halt_opcode();
        logic [19:0] exp_i [5];
        exp_i = '{20'h00503, 20'h00801, 20'h10802, 20'hF0000, 20'h104FB};
        do_reset();
        dec_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 8'(i) || dec_instr !== exp_i[i]) begin
                n_fail++;
                $display("FAIL opc_seq_%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, dec_valid, dec_pc, dec_instr, 8'(i), exp_i[i]);
            end
        end
`ifdef FETCH_HALT_EN
        n_checks++; if (halted !== 1'b1 || busy !== 1'b0 || imem_addr !== 8'h03) begin n_fail++; $display("FAIL halt_enter: got halted=%b busy=%b addr=%h want 1/0/03", halted, busy, imem_addr); end
        step();
        step();
        n_checks++; if (dec_valid !== 1'b0 || imem_addr !== 8'h03 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got v=%b addr=%h halted=%b want 0/03/1", dec_valid, imem_addr, halted); end
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        step();
        redirect_valid = 1'b0;
        n_checks++; if (busy !== 1'b1 || halted !== 1'b0 || imem_addr !== 8'h00) begin n_fail++; $display("FAIL halt_exit: got busy=%b halted=%b addr=%h want 1/0/00", busy, halted, imem_addr); end
        step();
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h00) begin n_fail++; $display("FAIL halt_refetch: got v=%b pc=%h want 1/00", dec_valid, dec_pc); end
`else
        step();
        n_checks++; if (dec_pc !== 8'h04 || dec_instr !== exp_i[4]) begin n_fail++; $display("FAIL opc_past_f: got %h/%h want 04/%h", dec_pc, dec_instr, exp_i[4]); end
        n_checks++; if (halted !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL opc_no_halt: got halted=%b busy=%b want 0/1", halted, busy); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {4'h1, 8'(i), ~8'(i)};
        end
        mem[0] = 20'h00503;
        mem[1] = 20'h00801;
        mem[2] = 20'h10802;
        mem[3] = 20'hF0000;

        test_reset();
        test_stream();
        test_raw_stall();
        test_redirect();
        test_pc_wrap();
        test_async_reset();
        test_halt_opcode();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before test completion");
        $fatal(1, "timeout");
    end

endmodule
